// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MEM stage: data width, funct3 access
// encodings, the access FSM state type and funct3 legality helpers.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mau_state_e;

    // Stores only have signed encodings; unsigned widths are load-only.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = a[0];
            F3_W:        bad = (a != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the bus word and
// sign- or zero-extends it to XLEN according to funct3.
module load_align
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection of the addressed byte and halfword.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Width/sign extension of the selected lane.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_HU:   o_data = {16'h0000, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32I pipeline: issues loads/stores on a req/gnt/rvalid
// data bus, steers store lanes, aligns load data, flags misaligned/illegal
// accesses and aborts accesses that see no bus response in time. Responses
// are presented in the same cycle the bus completes, so the result outputs
// are combinational on top of the registered FSM state.
module mem_access_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  mem_mem_data,
    output logic [XLEN-1:0]  mem_alu_result,
    output logic [4:0]       mem_rd,
    output logic             mem_regwrite,
    output logic             mem_memtoreg,
    output logic             mem_stall,
    output logic             mem_excp,
    output logic             mem_bus_err,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mau_state_e      r_state;
    mau_state_e      w_next;
    logic [CW-1:0]   r_cnt;

    logic            w_op;
    logic            w_store;
    logic            w_bad;
    logic            w_go;
    logic            w_timeout;
    logic            w_req;
    logic            w_complete;
    logic            w_abort;
    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;

    assign w_op      = ex_valid & (ex_memread | ex_memwrite);
    assign w_store   = ex_memwrite;
    assign w_bad     = w_op & (~f3_legal(w_store, ex_funct3) |
                               f3_misaligned(ex_funct3, ex_alu_result[1:0]));
    assign w_go      = w_op & ~w_bad;
    assign w_timeout = (r_cnt == CNT_LAST);

    load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (ex_alu_result[1:0]),
        .i_funct3  (ex_funct3),
        .o_data    (w_load_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timeout counter: restarts when an access leaves IDLE, counts REQ/WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Next-state, request and completion/abort decode.
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_req = 1'b1;
                    if (dmem_gnt) begin
                        if (w_store || dmem_rvalid) begin
                            w_complete = 1'b1;
                            w_next     = ST_IDLE;
                        end else begin
                            w_next    = ST_WAIT;
                            w_cnt_clr = 1'b1;
                        end
                    end else begin
                        w_next    = ST_REQ;
                        w_cnt_clr = 1'b1;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_cnt_inc = 1'b1;
                if (!w_go) begin
                    w_next = ST_IDLE;
                end else if (dmem_gnt) begin
                    w_req = 1'b1;
                    if (w_store || dmem_rvalid) begin
                        w_complete = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_req  = 1'b1;
                    w_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                w_cnt_inc = 1'b1;
                if (!w_go) begin
                    w_next = ST_IDLE;
                end else if (dmem_rvalid) begin
                    w_complete = 1'b1;
                    w_next     = ST_IDLE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Store lane steering: replicate the datum across lanes, enable only the addressed bytes.
    always_comb begin
        w_wdata = ex_rs2_data;
        w_wstrb = 4'b0000;
        case (ex_funct3)
            F3_B: begin
                w_wdata = {4{ex_rs2_data[7:0]}};
                w_wstrb = 4'b0001 << ex_alu_result[1:0];
            end
            F3_H: begin
                w_wdata = {2{ex_rs2_data[15:0]}};
                w_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
            end
            F3_W: begin
                w_wdata = ex_rs2_data;
                w_wstrb = 4'b1111;
            end
            default: begin
                w_wdata = ex_rs2_data;
                w_wstrb = 4'b0000;
            end
        endcase
        if (!(w_store && w_go)) begin
            w_wstrb = 4'b0000;
        end else begin
            w_wstrb = w_wstrb;
        end
    end

    // Output drive; everything is forced low while rst_n is asserted.
    always_comb begin
        mem_stall      = rst_n & w_op & ~w_bad & ~w_complete & ~w_abort;
        mem_excp       = rst_n & w_bad;
        mem_bus_err    = rst_n & w_abort;
        mem_regwrite   = rst_n & ex_valid & ex_regwrite & (~w_op | w_complete);
        dmem_req       = rst_n & w_req;
        dmem_we        = rst_n & w_store;
        dmem_wstrb     = rst_n ? w_wstrb : 4'b0000;
        dmem_wdata     = rst_n ? w_wdata : 32'h0000_0000;
        dmem_addr      = rst_n ? {ex_alu_result[31:2], 2'b00} : 32'h0000_0000;
        mem_alu_result = rst_n ? ex_alu_result : 32'h0000_0000;
        mem_rd         = rst_n ? ex_rd : 5'd0;
        mem_memtoreg   = rst_n & ex_memtoreg;
        if (rst_n && w_complete && !w_store) begin
            mem_mem_data = w_load_data;
        end else begin
            mem_mem_data = 32'h0000_0000;
        end
    end

endmodule
